l1_rx_bridge: RTL and testbench
===============================

Name: l1_rx_bridge

Overview:
- Receive-side bridge on the switch_5x5_XY L1 output port (ReqOutL1/DataOutL1/AckOutL1); replaces the bench-only ack responder in silicon.
- Accepts 2-phase bundled-data packets from the asynchronous switch and synchronizes the request into the core clock domain.
- Buffers packets in a small FIFO and presents them to the local neuron core over a synchronous valid/ready interface.
- Withholds the acknowledge toggle while the FIFO is full, which back-pressures the switch without dropping packets.

Parameters:
- DATA_W, 15, packet width: message bits above, ADDR_W address bits at the LSBs.
- ADDR_W, 5, address field width.
- FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flops in the request synchronizer; minimum 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ReqIn  in  1  2-phase request from the switch; a packet is signalled by any toggle.
- DataIn  in  DATA_W  bundled data. Stable from the ReqIn toggle until the AckIn toggle.
- AckIn  out  1  2-phase acknowledge to the switch; registered.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  core accepts the head.
- out_data  out  DATA_W  FIFO head packet.
- out_addr_err  out  1  head address field is 0 (malformed packet); qualified by out_valid.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- rx_count  out  16  packets accepted since reset; saturates at 16'hFFFF.

Behaviour:
Reset:
- rst asserted clears the synchronizer flops, ack_r and the FIFO pointers immediately, not waiting for a clock.
- Output values in reset: AckIn=0, out_valid=0, out_data=0, out_addr_err=0, fifo_level=0, rx_count=0.
- The switch must be reset together with this block so that ReqIn=0 at reset release.
- If ReqIn=1 at release, the block treats it as one pending packet and captures it. This is the defined behaviour, not an error.

Synchronizer:
- ReqIn passes through SYNC_STAGES flops; the last flop is req_s.
- pending = (req_s != ack_r).

Capture rule, evaluated every clock edge:
- If pending && !full:
  - write DataIn into FIFO[wr_ptr];
  - increment wr_ptr;
  - toggle ack_r (AckIn = ack_r);
  - increment rx_count, saturating.
- If pending && full:
  - no write and no toggle; AckIn holds.
  - Capture occurs on the first edge where full is deasserted.
- Exactly one capture per ReqIn toggle. After the toggle req_s == ack_r, so no double capture is possible.
- DataIn is sampled directly, without synchronizing. Bundled-data timing guarantees it has been stable for at least SYNC_STAGES cycles before req_s changes.

Latency:
- ReqIn toggle to capture edge: SYNC_STAGES edges plus 1, when the FIFO is not full.
- Capture edge to out_valid=1: the next cycle.
- The FIFO is registered, with no same-cycle write-to-read bypass.
- Capture edge to AckIn toggle: the same edge.

FIFO:
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- full = (wr_ptr - rd_ptr == FIFO_DEPTH); empty = (wr_ptr == rd_ptr).
- A pop occurs when out_valid && out_ready.
- Push eligibility is judged on the pre-edge full flag, so push is blocked while full even if a pop happens in the same cycle.
- A simultaneous push and pop when not full leaves fifo_level unchanged.
- out_data and out_addr_err are combinational from FIFO[rd_ptr]. out_data is 0 when empty.
- out_addr_err = (out_data[ADDR_W-1:0] == 0). The packet is still delivered; flagging only, no filtering.

Control FSM (2 states, encoding free):
- IDLE: AckIn is stable. Go to ACKED on an edge where pending && !full.
- ACKED: one cycle; the toggle is visible and no capture is allowed. Return to IDLE unconditionally.
- This enforces at most one capture every 2 cycles, independent of ReqIn glitches after the toggle.
- rst returns the FSM to IDLE.

Handshake contract:
- The switch must not toggle ReqIn again before observing the AckIn toggle.
- A violation can at most be seen as one merged event. It is not detected; verification only asserts the contract is never broken.

Test Plan:
- Reset: hold rst with ReqIn=0, then release → AckIn=0, out_valid=0, fifo_level=0, rx_count=0. Asserting rst mid-stream with fifo_level=3 → all three outputs clear asynchronously on the same timestep.
- Single packet: toggle ReqIn 0→1 with DataIn=15'h2A01, SYNC_STAGES=2 → AckIn toggles on the 3rd rising edge. out_valid=1 on the 4th edge with out_data=15'h2A01 and out_addr_err=0. rx_count=1.
- Back-pressure: hold out_ready=0 and send 6 packets, each paced by AckIn (FIFO_DEPTH=4):
  - 4 packets are acked; the 5th ReqIn toggle gets no AckIn response; fifo_level=4.
  - After one pop, the 5th packet is captured 1 edge later.
  - Final order of out_data matches send order; no loss or duplication.
- Streaming: out_ready=1 and the switch responds to AckIn immediately for 20 packets → 20 pops in send order, rx_count=20, at most one capture per 2 cycles.
- Malformed address: send DataIn=15'h7FE0 (address field 0) → delivered with out_addr_err=1. A following 15'h0011 is delivered with out_addr_err=0.
- Wrap and saturation:
  - Stream 8×FIFO_DEPTH packets → the pointers wrap cleanly and fifo_level never exceeds 4.
  - Force rx_count to 16'hFFFE, then send 3 packets → rx_count stops at 16'hFFFF.

Source files
------------

// File: rtl/l1_rx_bridge.sv
// Receive-side bridge for the switch L1 output port.
// Takes 2-phase bundled-data packets and synchronizes the request into clk.
// Packets are buffered in a small FIFO and delivered to the core over valid/ready.
// The ack toggle is withheld while the FIFO is full, back-pressuring the switch.
module l1_rx_bridge #(
  parameter int unsigned DATA_W      = 15,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ReqIn,
  input  logic [DATA_W-1:0]             DataIn,
  output logic                          AckIn,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_addr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   rx_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {ST_IDLE, ST_ACKED} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   ack_q;
  state_e                 state_q;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          vis_ptr_q;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [15:0]            rx_cnt_q;
  logic [PW-1:0]          level;
  logic                   pending;
  logic                   full;
  logic                   capture;
  logic                   valid;
  logic                   pop;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = (req_s != ack_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == PW'(FIFO_DEPTH));
  assign capture = (state_q == ST_IDLE) && pending && !full;
  assign valid   = (vis_ptr_q != rd_ptr_q);
  assign pop     = valid && out_ready;

  // Request synchronizer chain into the core clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ReqIn};
  end

  // Handshake FSM: capture toggles ack, then one dead cycle before the next capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q <= ST_ACKED;
            ack_q   <= ~ack_q;
          end
        end
        ST_ACKED: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Next-state pointer arithmetic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (capture) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // FIFO pointers; vis_ptr_q trails wr_ptr_q by one cycle so a freshly written
  // entry reaches the reader the cycle after capture, never in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      vis_ptr_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vis_ptr_q <= wr_ptr_q;
    end
  end

  // FIFO storage; DataIn is bundled and already stable when req_s changes
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q[AW-1:0]] <= DataIn;
  end

  // Saturating count of accepted packets
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               rx_cnt_q <= '0;
    else if (capture && (rx_cnt_q != '1))  rx_cnt_q <= rx_cnt_q + 16'd1;
  end

  assign AckIn        = ack_q;
  assign out_valid    = valid;
  assign out_data     = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_addr_err = valid && (out_data[ADDR_W-1:0] == '0);
  assign fifo_level   = level;
  assign rx_count     = rx_cnt_q;

endmodule

// File: tb/tb_l1_rx_bridge.sv
// Bench for l1_rx_bridge: directed vectors plus hand-written handshake sequences.
module tb_l1_rx_bridge;

  localparam int DATA_W      = 15;
  localparam int ADDR_W      = 5;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        ReqIn     = 1'b0;
  logic        out_ready = 1'b0;
  logic [14:0] DataIn    = '0;
  logic        AckIn;
  logic        out_valid;
  logic        out_addr_err;
  logic [14:0] out_data;
  logic [2:0]  fifo_level;
  logic [15:0] rx_count;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int cyc      = 0;
  int last_cap = -100;
  logic prev_ack = 1'b0;
  logic [14:0] exp_q[$];

  typedef struct {
    logic [14:0] data;
    logic        exp_err;
  } vec_t;

  l1_rx_bridge #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ReqIn(ReqIn),
    .DataIn(DataIn),
    .AckIn(AckIn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr_err(out_addr_err),
    .fifo_level(fifo_level),
    .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Toggle ReqIn with new data, then wait (bounded) for the ack toggle
  task automatic send_pkt(input logic [14:0] d, input int budget, output bit acked);
    logic a0;
    a0 = AckIn;
    DataIn = d;
    ReqIn = ~ReqIn;
    exp_q.push_back(d);
    acked = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (AckIn !== a0) begin
        acked = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: pop order against the scoreboard, capture spacing and occupancy bound
  always @(negedge clk) begin
    logic [14:0] e;
    #1;
    if (rst) begin
      prev_ack = 1'b0;
      last_cap = -100;
    end else begin
      cyc++;
      if (AckIn !== prev_ack) begin
        check("cap_spacing_ge2", 32'((cyc - last_cap) >= 2), 32'd1);
        check("level_le_depth", 32'(fifo_level <= 3'(FIFO_DEPTH)), 32'd1);
        last_cap = cyc;
        prev_ack = AckIn;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected no pop", out_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_order", 32'(out_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    logic [14:0] bp[6];
    logic        a0, a1;
    bit          acked;
    int          p0;

    vecs[0] = '{data: 15'h2A01, exp_err: 1'b0};
    vecs[1] = '{data: 15'h7FE0, exp_err: 1'b1};
    vecs[2] = '{data: 15'h0011, exp_err: 1'b0};
    vecs[3] = '{data: 15'h0020, exp_err: 1'b1};
    vecs[4] = '{data: 15'h001F, exp_err: 1'b0};
    vecs[5] = '{data: 15'h7FFF, exp_err: 1'b0};
    vecs[6] = '{data: 15'h0000, exp_err: 1'b1};
    vecs[7] = '{data: 15'h0001, exp_err: 1'b0};
    bp[0] = 15'h1001; bp[1] = 15'h2002; bp[2] = 15'h3003;
    bp[3] = 15'h4004; bp[4] = 15'h5005; bp[5] = 15'h6006;

    // Reset
    rst = 1'b1; ReqIn = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_ack", 32'(AckIn), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr_err", 32'(out_addr_err), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_rx", 32'(rx_count), 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("rel_ack", 32'(AckIn), 32'd0);
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_level", 32'(fifo_level), 32'd0);

    // Single packets: latency, delivery, address flag
    for (int i = 0; i < 8; i++) begin
      a0 = AckIn;
      a1 = ~a0;
      DataIn = vecs[i].data;
      ReqIn = ~ReqIn;
      exp_q.push_back(vecs[i].data);
      tick(); tick();
      check("vec_no_ack_before_edge3", 32'(AckIn), 32'(a0));
      tick();
      check("vec_ack_edge3", 32'(AckIn), 32'(a1));
      check("vec_valid_lags_capture", 32'(out_valid), 32'd0);
      check("vec_level_1", 32'(fifo_level), 32'd1);
      tick();
      check("vec_valid_edge4", 32'(out_valid), 32'd1);
      check("vec_data", 32'(out_data), 32'(vecs[i].data));
      check("vec_addr_err", 32'(out_addr_err), 32'(vecs[i].exp_err));
      check("vec_rx", 32'(rx_count), 32'(i + 1));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("vec_empty_after_pop", 32'(out_valid), 32'd0);
      check("vec_level_0", 32'(fifo_level), 32'd0);
    end

    // Back-pressure with out_ready held low
    for (int p = 0; p < 4; p++) begin
      send_pkt(bp[p], 12, acked);
      check("bp_acked", 32'(acked), 32'd1);
    end
    check("bp_level_full", 32'(fifo_level), 32'd4);
    a0 = AckIn;
    a1 = ~a0;
    DataIn = bp[4];
    ReqIn = ~ReqIn;
    exp_q.push_back(bp[4]);
    repeat (8) tick();
    check("bp_5th_held", 32'(AckIn), 32'(a0));
    check("bp_level_held", 32'(fifo_level), 32'd4);
    check("bp_head", 32'(out_data), 32'(bp[0]));
    check("bp_rx_12", 32'(rx_count), 32'd12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_no_capture_on_pop_edge", 32'(AckIn), 32'(a0));
    check("bp_level_after_pop", 32'(fifo_level), 32'd3);
    tick();
    check("bp_capture_after_pop", 32'(AckIn), 32'(a1));
    check("bp_level_refull", 32'(fifo_level), 32'd4);
    check("bp_rx_13", 32'(rx_count), 32'd13);
    send_pkt(bp[5], 8, acked);
    check("bp_6th_held", 32'(acked), 32'd0);
    out_ready = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_level_0", 32'(fifo_level), 32'd0);
    check("bp_rx_14", 32'(rx_count), 32'd14);

    // Asynchronous reset mid-stream with three entries held
    for (int p = 0; p < 3; p++) begin
      send_pkt(15'(16'h0A01 + p), 12, acked);
      check("mid_acked", 32'(acked), 32'd1);
    end
    check("mid_level_3", 32'(fifo_level), 32'd3);
    check("mid_ack_high", 32'(AckIn), 32'd1);
    #3;
    rst = 1'b1;
    ReqIn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ack", 32'(AckIn), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_rx", 32'(rx_count), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();

    // Streaming, switch answers every ack immediately
    out_ready = 1'b1;
    p0 = n_pops;
    for (int k = 0; k < 20; k++) begin
      send_pkt(15'(k * 613 + 9), 12, acked);
      check("stream_acked", 32'(acked), 32'd1);
    end
    repeat (6) tick();
    check("stream_pops", n_pops - p0, 32'd20);
    check("stream_drained", exp_q.size(), 32'd0);
    check("stream_rx_20", 32'(rx_count), 32'd20);

    // Pointer wrap over 8x depth
    p0 = n_pops;
    for (int k = 0; k < 8 * FIFO_DEPTH; k++) begin
      send_pkt(15'(k * 1021 + 1), 12, acked);
      check("wrap_acked", 32'(acked), 32'd1);
    end
    repeat (6) tick();
    check("wrap_pops", n_pops - p0, 32'd32);
    check("wrap_level_0", 32'(fifo_level), 32'd0);
    check("wrap_rx_52", 32'(rx_count), 32'd52);

    // Counter saturation
    force dut.rx_cnt_q = 16'hFFFE;
    tick();
    release dut.rx_cnt_q;
    tick();
    check("sat_preset", 32'(rx_count), 32'h0000FFFE);
    for (int k = 0; k < 3; k++) begin
      send_pkt(15'(16'h0101 + k), 12, acked);
      check("sat_acked", 32'(acked), 32'd1);
      check("sat_rx", 32'(rx_count), 32'h0000FFFF);
    end
    repeat (6) tick();
    check("sat_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
